// File: rtl/ice_uart_rx.sv
// ICE debug link UART receiver: 8N1 deserialiser feeding a show-ahead byte FIFO.
// Framing and overrun conditions are latched in sticky flags until I_CLR_ERR.
module ice_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 271,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic               CLK,
    input  logic               I_NRESET,
    input  logic               I_RX,
    output logic [7:0]         O_DATA,
    output logic               O_VALID,
    input  logic               I_READ,
    output logic [FIFO_AW:0]   O_LEVEL,
    output logic               O_FRAME_ERR,
    output logic               O_OVERRUN,
    input  logic               I_CLR_ERR
);

    localparam int unsigned Depth    = 2 ** FIFO_AW;
    localparam int unsigned HalfBit  = CLKS_PER_BIT / 2;
    localparam logic [15:0] CntLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CntHalf  = 16'(HalfBit - 1);
    localparam logic [FIFO_AW:0] LevelFull = (FIFO_AW + 1)'(Depth);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHi
    } state_e;

    // Input synchroniser; resets to the idle (high) line level.
    logic rx_meta_q, rx_sync_q;
    logic rxs;

    always_ff @(posedge CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= I_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rxs = rx_sync_q;

    // Receive FSM
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        push;
    logic        frame_evt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // Half a bit in: confirm the start bit and re-centre the sample point.
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_evt = 1'b1;
                        state_d   = StWaitHi;
                    end
                end
            end
            StWaitHi: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = StIdle;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Show-ahead FIFO; pointers carry one extra bit so full and empty are distinct.
    logic [7:0]       mem_q [Depth];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0] level;
    logic             empty, full;
    logic             pop, wr_en, overrun_evt;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        level       = wr_ptr_q - rd_ptr_q;
        empty       = (level == '0);
        full        = (level == LevelFull);
        pop         = I_READ & ~empty;
        wr_en       = push & (~full | pop);
        overrun_evt = push & full & ~pop;
        wr_ptr_d    = wr_ptr_q + {{FIFO_AW{1'b0}}, wr_en};
        rd_ptr_d    = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        // Error events take priority over a simultaneous clear.
        frame_err_d = (frame_err_q & ~I_CLR_ERR) | frame_evt;
        overrun_d   = (overrun_q & ~I_CLR_ERR) | overrun_evt;
    end

    always_ff @(posedge CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
        end
    end

    assign O_VALID     = ~empty;
    assign O_LEVEL     = level;
    assign O_DATA      = empty ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign O_FRAME_ERR = frame_err_q;
    assign O_OVERRUN   = overrun_q;

endmodule

// File: tb/tb_ice_uart_rx.sv
// Self-checking bench for ice_uart_rx: directed scenarios plus randomized frames
// compared against a queue-based model of the receive FIFO and sticky flags.
module tb_ice_uart_rx;

    localparam int CPB   = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;
    localparam int HB    = CPB / 2;
    // Edges after the start-bit drive: 2 sync flops, 1 idle detect, half bit, 8 data + stop.
    localparam int STOP_SMP = 3 + HB + 9 * CPB;

    logic          CLK = 1'b0;
    logic          I_NRESET;
    logic          I_RX;
    logic [7:0]    O_DATA;
    logic          O_VALID;
    logic          I_READ;
    logic [AW:0]   O_LEVEL;
    logic          O_FRAME_ERR;
    logic          O_OVERRUN;
    logic          I_CLR_ERR;

    ice_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .CLK         (CLK),
        .I_NRESET    (I_NRESET),
        .I_RX        (I_RX),
        .O_DATA      (O_DATA),
        .O_VALID     (O_VALID),
        .I_READ      (I_READ),
        .O_LEVEL     (O_LEVEL),
        .O_FRAME_ERR (O_FRAME_ERR),
        .O_OVERRUN   (O_OVERRUN),
        .I_CLR_ERR   (I_CLR_ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    logic       m_ferr;
    logic       m_ovr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Drive one frame starting now (caller is on a negedge). stop_low > 0 holds the
    // stop bit low for that many bit times, then returns the line high for one bit.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        I_RX = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            I_RX = b[i];
            wait_cycles(CPB);
        end
        if (stop_low == 0) begin
            I_RX = 1'b1;
            wait_cycles(CPB);
        end else begin
            I_RX = 1'b0;
            wait_cycles(stop_low * CPB);
            I_RX = 1'b1;
            wait_cycles(CPB);
        end
    endtask

    function automatic void model_good_byte(input logic [7:0] b);
        if (exp_q.size() == DEPTH) m_ovr = 1'b1;
        else exp_q.push_back(b);
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".level"}, 32'(O_LEVEL), 32'(exp_q.size()));
        check_eq({tag, ".valid"}, 32'(O_VALID), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check_eq({tag, ".head"}, 32'(O_DATA), 32'(exp_q[0]));
        check_eq({tag, ".ferr"}, 32'(O_FRAME_ERR), 32'(m_ferr));
        check_eq({tag, ".ovr"}, 32'(O_OVERRUN), 32'(m_ovr));
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() != 0) begin
            check_eq({tag, ".pop_data"}, 32'(O_DATA), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        check_eq({tag, ".pop_valid"}, 32'(O_VALID), 32'(1));
        I_READ = 1'b1;
        wait_cycles(1);
        I_READ = 1'b0;
    endtask

    task automatic clear_err();
        I_CLR_ERR = 1'b1;
        wait_cycles(1);
        I_CLR_ERR = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        I_NRESET  = 1'b0;
        I_RX      = 1'b1;
        I_READ    = 1'b0;
        I_CLR_ERR = 1'b0;
        m_ferr    = 1'b0;
        m_ovr     = 1'b0;
        wait_cycles(3);
        check_all("reset");
        check_eq("reset.data", 32'(O_DATA), 32'h0);
        I_NRESET = 1'b1;
        wait_cycles(CPB);

        // Single byte with exact write latency.
        fork
            send_frame(8'hA5, 0);
            begin
                wait_cycles(STOP_SMP - 1);
                check_eq("lat.before", 32'(O_VALID), 32'(0));
                wait_cycles(1);
                check_eq("lat.after", 32'(O_VALID), 32'(1));
                check_eq("lat.data", 32'(O_DATA), 32'hA5);
            end
        join
        model_good_byte(8'hA5);
        check_all("a5");
        pop_check("a5");
        check_all("a5_popped");

        // Back-to-back frames.
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        send_frame(8'h55, 0);
        model_good_byte(8'h00);
        model_good_byte(8'hFF);
        model_good_byte(8'h55);
        check_all("b2b");
        for (int i = 0; i < 3; i++) pop_check("b2b");

        // Start-bit glitch is rejected, then a normal frame still decodes.
        I_RX = 1'b0;
        wait_cycles(5);
        I_RX = 1'b1;
        wait_cycles(2 * CPB);
        check_all("glitch");
        send_frame(8'hC3, 0);
        model_good_byte(8'hC3);
        check_all("post_glitch");
        pop_check("post_glitch");

        // Long-low stop bit: framing error, byte discarded, recovery.
        send_frame(8'h3C, 3);
        m_ferr = 1'b1;
        check_all("ferr");
        send_frame(8'h42, 0);
        model_good_byte(8'h42);
        check_all("ferr_next");
        clear_err();
        check_all("ferr_clr");
        pop_check("ferr_next");

        // Overflow: 17 bytes, last dropped.
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 0);
            model_good_byte(8'(i));
        end
        check_all("ovf");
        check_eq("ovf.head", 32'(O_DATA), 32'h01);
        for (int i = 0; i < DEPTH; i++) pop_check("ovf_drain");
        check_all("ovf_empty");
        clear_err();

        // Full FIFO with a pop on the exact push cycle.
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 0);
            model_good_byte(b);
        end
        check_all("full");
        fork
            send_frame(8'h77, 0);
            begin
                wait_cycles(STOP_SMP - 1);
                I_READ = 1'b1;
                wait_cycles(1);
                I_READ = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        check_all("full_pop_push");
        for (int i = 0; i < DEPTH; i++) pop_check("full_drain");
        check_all("full_empty");

        // Reset asserted in the middle of a data bit.
        send_frame(8'h5A, 0);
        send_frame(8'h11, 2);
        model_good_byte(8'h5A);
        m_ferr = 1'b1;
        check_all("pre_rst");
        I_RX = 1'b0;
        wait_cycles(CPB);
        I_RX = 1'b1;
        wait_cycles(CPB + 5);
        I_NRESET = 1'b0;
        #1;
        exp_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        check_all("mid_rst");
        check_eq("mid_rst.data", 32'(O_DATA), 32'h0);
        wait_cycles(2);
        I_NRESET = 1'b1;
        wait_cycles(2 * CPB * 10);
        check_all("post_rst");
        send_frame(8'h99, 0);
        model_good_byte(8'h99);
        check_all("post_rst_rx");

        // Randomized traffic: mixed good and bad frames, reads and clears.
        for (int it = 0; it < 40; it++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                send_frame(b, 1);
                m_ferr = 1'b1;
            end else begin
                send_frame(b, 0);
                model_good_byte(b);
            end
            if ($urandom_range(0, 1) == 1) begin
                if (exp_q.size() != 0) begin
                    pop_check("rnd");
                end else begin
                    I_READ = 1'b1;
                    wait_cycles(1);
                    I_READ = 1'b0;
                end
            end
            if ($urandom_range(0, 5) == 0) clear_err();
            check_all("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ice_uart_rx.md
Name: ice_uart_rx

Overview:
Serial receiver for the ICE debug link. It sits between the board RX pin and the ice command decoder, in the CPU clock domain. It deserialises 8N1 UART frames and buffers received bytes in a small show-ahead FIFO. The ice block pops bytes at its own pace; framing and overflow errors are reported through sticky flags.

Parameters:
CLKS_PER_BIT, 271, CLK cycles per bit period (31.25 MHz / 115200 baud, rounded); legal range 8..65535
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries (default 16)

Ports:
CLK  in  1  CPU clock (CLK_31M25 domain)
I_NRESET  in  1  asynchronous active-low reset
I_RX  in  1  raw serial input, idle high, asynchronous to CLK
O_DATA  out  8  byte at FIFO head; valid only while O_VALID=1
O_VALID  out  1  FIFO not empty
I_READ  in  1  pop strobe; honoured only when O_VALID=1
O_LEVEL  out  FIFO_AW+1  number of bytes held, 0..2**FIFO_AW
O_FRAME_ERR  out  1  sticky: a stop bit was sampled low
O_OVERRUN  out  1  sticky: a good byte was dropped because the FIFO was full
I_CLR_ERR  in  1  clears both sticky flags

Behaviour:
- Reset is asynchronous and active-low. While I_NRESET=0: O_VALID=0, O_LEVEL=0, O_DATA=0, O_FRAME_ERR=0, O_OVERRUN=0, FSM=IDLE, synchroniser flops=1, pointers=0.
- Reset asserted mid-frame aborts the frame and empties the FIFO. After release, the receiver waits for a fresh falling edge.
- I_RX passes through a 2-flop synchroniser; the FSM uses only the synchronised signal rxs.
- The bit counter cnt counts 0..CLKS_PER_BIT-1. H = CLKS_PER_BIT/2 (integer division).
- FSM:
  - IDLE: on rxs=0, clear cnt and go to START.
  - START: when cnt=H-1, sample rxs. If rxs=1 (glitch), go to IDLE with no flag. If rxs=0, clear cnt and go to DATA. The sample point is now the bit centre.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into the shift register, LSB first. After the 8th bit, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - If rxs=1: push the byte and go to IDLE.
    - If rxs=0: set O_FRAME_ERR, discard the byte, go to WAIT_HI.
  - WAIT_HI: stay until rxs=1 (this covers break conditions), then go to IDLE.
- Latency: the byte is written on the cycle of the stop-bit sample, and O_VALID/O_DATA update on the following edge.
- FIFO is show-ahead: O_DATA always shows the head entry. A pop (I_READ & O_VALID) advances the head on the next edge.
- Pointers are FIFO_AW+1 bits and wrap naturally. O_LEVEL = wr_ptr - rd_ptr.
- Push when full with no pop in the same cycle: the byte is dropped, O_OVERRUN is set, and FIFO contents are unchanged.
- Push and pop in the same cycle while full: both take effect and O_LEVEL stays at 2**FIFO_AW. No overrun.
- Push and pop in the same cycle while empty: the pop is ignored, the push is accepted, and O_LEVEL becomes 1.
- I_READ while O_VALID=0 has no effect.
- Sticky flags: I_CLR_ERR clears them on the next edge. If an error event occurs in the same cycle as I_CLR_ERR, the set wins.
- The FIFO read and write pointers are separate registers, so a completed frame is never lost to a concurrent pop.

Test Plan:
- Reset, then send 0xA5 at CLKS_PER_BIT=16 → O_VALID rises 1 cycle after the stop sample. O_DATA=0xA5, O_LEVEL=1. Pulse I_READ → O_VALID=0, O_LEVEL=0.
- Send 0x00, 0xFF, 0x55 back-to-back, with the stop bit followed immediately by the next start bit → FIFO holds 0x00, 0xFF, 0x55 in order. No flags set.
- Pulse I_RX low for 5 cycles only (CLKS_PER_BIT=16) → no byte, no flag, FSM back in IDLE.
- Send a frame 0x3C with the stop bit held low for 3 bit times → O_FRAME_ERR=1, O_LEVEL unchanged. The next valid frame 0x42 is received correctly. I_CLR_ERR → flag=0.
- Send 17 bytes 0x01..0x11 with no reads (FIFO_AW=4) → O_LEVEL=16, O_OVERRUN=1, head=0x01, byte 0x11 lost. Then 16 pops return 0x01..0x10.
- With the FIFO full, pulse I_READ exactly on the push cycle of 0x77 → O_LEVEL stays 16, no overrun, and 0x77 is the last entry. Also assert I_NRESET=0 mid-DATA → all outputs return to 0 immediately.
